video_out_timing: RTL and testbench
===================================

# video_out_timing

Display-side stage that consumes the aligned pixel stream (RGB565, one line per burst, `in_vs` pulse after the last line of a frame) and regenerates a standard raster with HS/VS/DE. It holds two line buffers (ping-pong), locks the raster to the incoming frame boundary, and expands RGB565 to RGB888 for the HDMI/DVI encoder. Everything runs in the `video_clk` domain.

## Interface
- `H_DISP`, 1280, active pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 110 / 40 / 220, horizontal porch and sync widths in pixels
- `V_DISP`, 720, active lines
- `V_FP` / `V_SYNC` / `V_BP`, 5 / 5 / 20, vertical porch and sync widths in lines
- `HS_POL` / `VS_POL`, 1 / 1, active level of the sync outputs
- `FILL`, 24'h000000, RGB888 value driven on an underflowed active line
- `video_clk`, in, 1, pixel clock
- `rst`, in, 1, reset: asynchronous, active-high
- `in_data`, in, 16, RGB565 pixel {R5,G6,B5}
- `in_valid`, in, 1, `in_data` valid this cycle
- `in_vs`, in, 1, one-cycle pulse marking the end of an input frame
- `out_de`, out, 1, active video
- `out_hs`, out, 1, horizontal sync
- `out_vs`, out, 1, vertical sync
- `out_rgb`, out, 24, RGB888 pixel
- `locked`, out, 1, raster is locked to the input frames
- `underflow`, out, 1, one-cycle pulse: active line started with no buffered line
- `overflow`, out, 1, one-cycle pulse: an input line arrived while both buffers were full

## Operation
- Totals: `H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP`, `V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP`. Counter widths are `$clog2(total)`.
- Raster counters `h_cnt` and `v_cnt` run free from reset.
  - Origin is the first active pixel.
  - Active region: `h_cnt<H_DISP` and `v_cnt<V_DISP`.
  - HS is asserted for `H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC`; VS uses the same rule on `v_cnt`.
  - `v_cnt` advances when `h_cnt==H_TOTAL-1`.
- Write side:
  - `wr_x` counts valid pixels and writes `in_data` to bank `wr_bank` at address `wr_x`.
  - On a valid pixel with `wr_x==H_DISP-1`: `wr_x` returns to 0, `wr_bank` toggles, `lines_ready` increments.
  - If `lines_ready==2` when a line would start (a valid pixel arrives at `wr_x==0`), the whole line is discarded and `overflow` pulses once.
- Read side: at `h_cnt==0` on an active line while `locked`:
  - If `lines_ready>0`: claim bank `rd_bank`, read addresses 0..H_DISP-1, then toggle `rd_bank` and decrement `lines_ready` at `h_cnt==H_DISP-1`.
  - Else: drive `FILL` for the line and pulse `underflow`.
- When the write-side increment and the read-side decrement of `lines_ready` fall in the same cycle, the net change is 0.
- Lock FSM:
  - UNLOCK (reset state): `locked=0`, active pixels output `FILL`, buffers are written but never read. `in_vs` → FLUSH.
  - FLUSH: `wr_x=0`, `wr_bank=rd_bank=0`, `lines_ready=0`. Stays in FLUSH until the last pixel of the raster (`h_cnt==H_TOTAL-1`, `v_cnt==V_TOTAL-1`), then → RUN.
  - RUN: `locked=1`. An `in_vs` pulse while `wr_x!=0` clears `wr_x` (the partial line is dropped) and stays in RUN. 8 consecutive underflowing lines → UNLOCK.
  - `in_vs` in the same cycle as a final write pixel: the line completes first, then the `in_vs` rule applies.
- Colour expansion:
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- `out_rgb = 0` whenever `out_de=0`.

## Timing
- Reset values: `out_de=0`, `out_hs=!HS_POL`, `out_vs=!VS_POL`, `out_rgb=0`, `locked=0`, `underflow=0`, `overflow=0`; counters, `lines_ready` and both banks are cleared, FSM=UNLOCK.
- Asserting `rst` mid-frame returns all of the above within the same cycle (asynchronous reset).
- Pipeline, counters to outputs, is 2 cycles:
  - Cycle t: counters drive the buffer read address.
  - Cycle t+1: synchronous RAM data.
  - Cycle t+2: registered `out_de`/`out_hs`/`out_vs`/`out_rgb`.
- Sync and DE are delayed by the same 2 stages, so pixel alignment is exact.
- Write latency: a pixel written at cycle t is readable at cycle t+1. A line is readable from the cycle after its last pixel is written.
- `underflow`/`overflow` pulse at output stage t+2 relative to the triggering event. `locked` is registered and changes 1 cycle after the FSM transition.

## Test plan
- Small raster (`H_DISP=8`, `H_FP=2`, `H_SYNC=2`, `H_BP=2`, `V_DISP=4`, `V_FP=V_SYNC=V_BP=1`), no input → HS high 2 of every 14 cycles, VS high for 14 cycles per 98, DE high 8 cycles per active line, `out_rgb=FILL`, `locked=0`.
- Same raster: pulse `in_vs`, then feed 4 lines of 8 pixels (pixel value = line*8+x) in time → `locked=1` at the next frame start; first active pixel `out_rgb` equals the expansion of 16'h0000, and pixel 16'hF81F → 24'hFF00FF.
- Starve line 2 of a locked frame → `underflow` pulses once, that line outputs `FILL`, and lines 3–4 output correct data.
- Feed 3 lines back-to-back before any active line is read → `overflow` pulses once, the third line is dropped, and `lines_ready` saturates at 2.
- Locked, then stop all input for 8 active lines → `locked` drops after the 8th underflow and the FSM returns to UNLOCK; the next `in_vs` relocks one frame later.
- Assert `rst` mid-line while locked → all outputs at reset values the same cycle; after release, HS first asserts at `h_cnt=H_DISP+H_FP` (+2 cycles).

Source files
------------

// File: rtl/video_out_timing.sv
// Raster regenerator: ping-pong line buffers fed by the aligned RGB565 stream,
// locked to input frame boundaries, emitting registered RGB888 with HS/VS/DE.
module video_out_timing #(
  parameter int          H_DISP = 1280,
  parameter int          H_FP   = 110,
  parameter int          H_SYNC = 40,
  parameter int          H_BP   = 220,
  parameter int          V_DISP = 720,
  parameter int          V_FP   = 5,
  parameter int          V_SYNC = 5,
  parameter int          V_BP   = 20,
  parameter logic        HS_POL = 1'b1,
  parameter logic        VS_POL = 1'b1,
  parameter logic [23:0] FILL   = 24'h000000
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_vs,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [23:0] out_rgb,
  output logic        locked,
  output logic        underflow,
  output logic        overflow
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_DISP);
  localparam logic [HW-1:0] H_RD_END = HW'(H_DISP - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_DISP + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_DISP + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_DISP);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_DISP + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_DISP + V_FP + V_SYNC);
  localparam logic [AW-1:0] WX_LAST  = AW'(H_DISP - 1);
  localparam logic [AW:0]   BANK1    = (AW+1)'(H_DISP);

  localparam logic [1:0] ST_UNLOCK = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [1:0]    r_state;
  logic [2:0]    r_uf_cnt;
  logic [AW-1:0] r_wr_x;
  logic          r_wr_bank, r_rd_bank, r_drop, r_claim;
  logic [1:0]    r_lines_ready;
  logic [15:0]   r_mem [0:2*H_DISP-1];
  logic [15:0]   r_rd_data;
  logic          r_de1, r_hs1, r_vs1, r_src1, r_uf1, r_ov1, r_locked;

  logic          w_act, w_hs, w_vs, w_run, w_flush, w_line_start, w_claim, w_uf_evt;
  logic          w_src_data, w_rd_release, w_wr_last, w_ov_evt, w_discard, w_wr_en, w_line_done;
  logic [AW-1:0] w_rd_x;
  logic [AW:0]   w_rd_addr, w_wr_addr;
  logic [23:0]   w_rgb888;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_act        = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs         = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs         = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_run        = (r_state == ST_RUN);
  assign w_flush      = (r_state == ST_FLUSH);
  assign w_line_start = w_act && w_run && (r_h_cnt == '0);
  assign w_claim      = w_line_start && (r_lines_ready != 2'd0);
  assign w_uf_evt     = w_line_start && (r_lines_ready == 2'd0);
  // The claim decision is taken at h_cnt==0 and held for the rest of the line.
  assign w_src_data   = w_act && w_run && ((r_h_cnt == '0) ? (r_lines_ready != 2'd0) : r_claim);
  assign w_rd_release = w_src_data && (r_h_cnt == H_RD_END);
  assign w_rd_x       = (r_h_cnt < H_ACT) ? r_h_cnt[AW-1:0] : '0;
  assign w_rd_addr    = r_rd_bank ? ({1'b0, w_rd_x} + BANK1) : {1'b0, w_rd_x};

  assign w_wr_last    = in_valid && (r_wr_x == WX_LAST);
  assign w_ov_evt     = in_valid && (r_wr_x == '0) && (r_lines_ready == 2'd2) && !w_flush;
  assign w_discard    = r_drop || w_ov_evt;
  assign w_wr_en      = in_valid && !w_discard && !w_flush;
  assign w_line_done  = w_wr_last && !w_discard;
  assign w_wr_addr    = r_wr_bank ? ({1'b0, r_wr_x} + BANK1) : {1'b0, r_wr_x};

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_wr_x        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_lines_ready <= 2'd0;
      r_drop        <= 1'b0;
      r_claim       <= 1'b0;
    end else if (w_flush) begin
      r_wr_x        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_lines_ready <= 2'd0;
      r_drop        <= 1'b0;
      r_claim       <= 1'b0;
    end else begin
      if (r_h_cnt == '0) r_claim <= w_claim;
      if (in_valid) begin
        r_wr_x <= w_wr_last ? '0 : r_wr_x + 1'b1;
        r_drop <= w_discard && !w_wr_last;
      end
      if (w_line_done)  r_wr_bank <= ~r_wr_bank;
      if (w_rd_release) r_rd_bank <= ~r_rd_bank;
      case ({w_line_done, w_rd_release})
        2'b10:   r_lines_ready <= r_lines_ready + 2'd1;
        2'b01:   r_lines_ready <= r_lines_ready - 2'd1;
        default: r_lines_ready <= r_lines_ready;
      endcase
      // Frame marker in RUN drops any partial line after a completing pixel is counted.
      if (in_vs && w_run) begin
        r_wr_x <= '0;
        r_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge video_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= in_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_UNLOCK;
      r_uf_cnt <= '0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= w_run;
      case (r_state)
        ST_UNLOCK: begin
          r_uf_cnt <= '0;
          if (in_vs) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_uf_cnt <= '0;
          if ((r_h_cnt == H_LAST) && (r_v_cnt == V_LAST)) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_uf_evt) begin
            r_uf_cnt <= r_uf_cnt + 1'b1;
            if (r_uf_cnt == 3'd7) r_state <= ST_UNLOCK;
          end else if (w_claim) begin
            r_uf_cnt <= '0;
          end
        end
        default: r_state <= ST_UNLOCK;
      endcase
    end
  end

  assign w_rgb888 = {r_rd_data[15:11], r_rd_data[15:13],
                     r_rd_data[10:5],  r_rd_data[10:9],
                     r_rd_data[4:0],   r_rd_data[4:2]};

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_de1     <= 1'b0;
      r_hs1     <= ~HS_POL;
      r_vs1     <= ~VS_POL;
      r_src1    <= 1'b0;
      r_uf1     <= 1'b0;
      r_ov1     <= 1'b0;
      out_de    <= 1'b0;
      out_hs    <= ~HS_POL;
      out_vs    <= ~VS_POL;
      out_rgb   <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_de1     <= w_act;
      r_hs1     <= w_hs ? HS_POL : ~HS_POL;
      r_vs1     <= w_vs ? VS_POL : ~VS_POL;
      r_src1    <= w_src_data;
      r_uf1     <= w_uf_evt;
      r_ov1     <= w_ov_evt;
      out_de    <= r_de1;
      out_hs    <= r_hs1;
      out_vs    <= r_vs1;
      out_rgb   <= r_de1 ? (r_src1 ? w_rgb888 : FILL) : 24'h000000;
      underflow <= r_uf1;
      overflow  <= r_ov1;
    end
  end

  assign locked = r_locked;

endmodule

// File: tb/tb_video_out_timing.sv
// Directed bench for video_out_timing on a 14x7 raster: sync shape, lock,
// colour expansion, overflow/underflow, lock loss, relock and async reset.
module tb_video_out_timing;
  localparam int HD = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VD = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = 14, VT = 7, FT = 98;
  localparam logic [23:0] FILLV = 24'hA5C33C;

  logic        video_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_vs = 1'b0;
  logic        out_de, out_hs, out_vs, locked, underflow, overflow;
  logic [23:0] out_rgb;

  always #5 video_clk = ~video_clk;

  video_out_timing #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .FILL(FILLV)
  ) dut (
    .video_clk(video_clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_vs(in_vs),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb),
    .locked(locked), .underflow(underflow), .overflow(overflow)
  );

  typedef struct packed {
    logic [15:0] pix;
    logic [23:0] rgb;
  } vec_t;
  vec_t vecs [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  function automatic logic [23:0] exp565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Outputs during cycle n reflect raster position of cycle n-2.
  task automatic mon();
    int p, hc, vc;
    p  = cyc - 2;
    hc = p % HT;
    vc = (p / HT) % VT;
    chk("de_shape", out_de, (hc < HD) && (vc < VD));
    chk("hs_shape", out_hs, (hc >= HD + HF) && (hc < HD + HF + HSY));
    chk("vs_shape", out_vs, (vc >= VD + VF) && (vc < VD + VF + VSY));
    if (!out_de) chk("rgb_blank", out_rgb, 24'h0);
  endtask

  task automatic tick();
    @(posedge video_clk);
    #1;
    cyc++;
    if (mon_en && cyc >= 2) mon();
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < FT && (cyc % FT) != p; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_de"}, out_de, 1'b0);
    chk({tag, "_hs"}, out_hs, 1'b0);
    chk({tag, "_vs"}, out_vs, 1'b0);
    chk({tag, "_rgb"}, out_rgb, 24'h0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_uf"}, underflow, 1'b0);
    chk({tag, "_ov"}, overflow, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int hs_n, vs_n, de_n, uf_n, ov_n, p, x, f0;
    vecs[0] = '{16'h0000, 24'h000000};
    vecs[1] = '{16'hF81F, 24'hFF00FF};
    vecs[2] = '{16'hFFFF, 24'hFFFFFF};
    vecs[3] = '{16'h07E0, 24'h00FF00};
    vecs[4] = '{16'h0821, 24'h080408};
    vecs[5] = '{16'h8410, 24'h848284};
    vecs[6] = '{16'h52AA, 24'h525552};
    vecs[7] = '{16'h001F, 24'h0000FF};

    repeat (3) @(posedge video_clk);
    #1;
    chk_reset_vals("rst_init");
    rst = 1'b0;
    cyc = 0;
    mon_en = 1'b1;

    // Free-running, unlocked: one frame of output
    hs_n = 0; vs_n = 0; de_n = 0;
    repeat (99) begin
      tick();
      hs_n += int'(out_hs);
      vs_n += int'(out_vs);
      de_n += int'(out_de);
      chk("unlocked", locked, 1'b0);
      if (out_de) chk("unlock_fill", out_rgb, FILLV);
    end
    chk("hs_count", hs_n, 14);
    chk("vs_count", vs_n, 14);
    chk("de_count", de_n, 32);

    // Lock: in_vs -> FLUSH -> RUN at next frame start
    wait_pos(50);
    in_vs = 1'b1;
    tick();
    in_vs = 1'b0;
    wait_pos(0);
    f0 = cyc;
    chk("lock_lag", locked, 1'b0);
    tick();
    chk("lock_on", locked, 1'b1);

    // Frame F: starved lines, then three lines back-to-back in vblank
    uf_n = 0; ov_n = 0;
    while (cyc < f0 + FT) begin
      p = cyc - f0;
      uf_n += int'(underflow);
      if (overflow) begin
        ov_n++;
        chk("ov_pos", p, 78);
      end
      if (p >= 60 && p < 84) begin
        x = (p - 60) % 8;
        in_valid = 1'b1;
        case ((p - 60) / 8)
          0:       in_data = vecs[x].pix;
          1:       in_data = 16'(8 + x);
          default: in_data = 16'(16'h7770 + x);
        endcase
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("uf_frame0", uf_n, 4);
    chk("ov_once", ov_n, 1);

    // Frame F+1: lines 0,1 buffered, line 2 starved, line 3 fed just in time
    uf_n = 0; ov_n = 0;
    while (cyc < f0 + 2 * FT) begin
      p = cyc - (f0 + FT);
      uf_n += int'(underflow);
      ov_n += int'(overflow);
      if (p >= 2 && p <= 9) begin
        x = p - 2;
        $display("vec %0d pix %04h rgb %06h exp %06h", x, vecs[x].pix, out_rgb, vecs[x].rgb);
        chk("vec_rgb", out_rgb, vecs[x].rgb);
      end
      if (p >= 16 && p <= 23) chk("line1_rgb", out_rgb, exp565(16'(8 + p - 16)));
      if (p >= 30 && p <= 37) chk("line2_fill", out_rgb, FILLV);
      if (p >= 44 && p <= 51) chk("line3_rgb", out_rgb, exp565(16'(24 + p - 44)));
      if (p == 30) chk("uf_pos", underflow, 1'b1);
      if (p >= 29 && p <= 36) begin
        in_valid = 1'b1;
        in_data  = 16'(24 + p - 29);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("uf_frame1", uf_n, 1);
    chk("ov_frame1", ov_n, 0);

    // Frames F+2, F+3: no input -> 8 underflows -> unlock; then relock
    uf_n = 0;
    while (cyc < f0 + 4 * FT) begin
      p = cyc - (f0 + 3 * FT);
      uf_n += int'(underflow);
      if (out_de) chk("starve_fill", out_rgb, FILLV);
      if (p == 43) chk("lock_hold", locked, 1'b1);
      if (p == 44) chk("lock_lost", locked, 1'b0);
      in_vs = (p == 60);
      tick();
    end
    in_vs = 1'b0;
    chk("uf_total8", uf_n, 8);
    chk("relock_lag", locked, 1'b0);
    tick();
    chk("relock_on", locked, 1'b1);

    // Asynchronous reset mid-line while locked
    while (cyc < f0 + 4 * FT + 17) tick();
    chk("pre_rst_de", out_de, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    repeat (2) @(posedge video_clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    mon_en = 1'b1;
    repeat (12) begin
      tick();
      if (cyc == 11) chk("hs_pre", out_hs, 1'b0);
      if (cyc == 12) chk("hs_first", out_hs, 1'b1);
    end
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
